hist_acq_sched: RTL and testbench

- Acquisition scheduler for the TDC histogram RAM controller.
- Sequences one or more histogram frames: arm, acquire, stop, read out, clear.
- Drives the RAM controller's capture, rd_en and header inputs, and gates hits into it.
- Monitors the output stream handshake to detect readout completion. Sits between the command/config registers and the histogram RAM controller.

---
 rtl/hist_acq_pkg.sv | 30 +++
 rtl/hist_acq_sched_if.sv | 17 +
 rtl/hist_limit_cnt.sv | 58 +++++
 rtl/hist_acq_sched.sv | 180 ++++++++++++++++++
 tb/tb_hist_acq_sched.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/hist_acq_pkg.sv
// Shared types and constants for the histogram acquisition scheduler.
package hist_acq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      ACQ,
      STOP,
      READ,
      CLEAR,
      NEXT
   } state_e;

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_COUNT = 2'b01;
   localparam logic [1:0] CAUSE_TIME  = 2'b10;
   localparam logic [1:0] CAUSE_ABORT = 2'b11;

   localparam logic [3:0] HDR_SYNC = 4'hA;

   localparam int ARM_CYCLES  = 4;
   localparam int STOP_CYCLES = 2;

   function automatic logic [31:0] make_hdr(input logic [1:0]  cause,
                                            input logic [7:0]  fid,
                                            input logic [15:0] cnt);
      return {HDR_SYNC, cause, 2'b00, fid, cnt};
   endfunction

endpackage

// File: rtl/hist_acq_sched_if.sv
// Scheduler <-> histogram RAM controller link: control outputs plus the monitored stream handshake.
interface hist_acq_sched_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   logic                           hit_gate;
   logic                           capture;
   logic                           rd_en;
   logic [ADDR_WIDTH+DATA_WIDTH-1:0] header;
   logic                           strm_valid;
   logic                           strm_ready;

   modport master (output hit_gate, capture, rd_en, header,
                   input  strm_valid, strm_ready);
   modport slave  (input  hit_gate, capture, rd_en, header,
                   output strm_valid, strm_ready);
endinterface

// File: rtl/hist_limit_cnt.sv
// Per-frame hit/time counters with limit compare; stop and cause are valid in the same cycle.
module hist_limit_cnt
   import hist_acq_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         clr,
   input  logic         en,
   input  logic         hit,
   input  logic         abort,
   input  logic [W-1:0] max_count,
   input  logic [W-1:0] max_time,
   output logic         stop,
   output logic [1:0]   cause,
   output logic [W-1:0] hit_cnt
);
   logic [W-1:0] hit_cnt_q, hit_cnt_d;
   logic [W-1:0] time_cnt_q, time_cnt_d;
   logic [W:0]   hit_next, time_next;
   logic         count_hit, time_hit;

   always_comb begin
      // One extra bit so an all-ones counter plus one never aliases a small limit.
      hit_next   = {1'b0, hit_cnt_q} + {{W{1'b0}}, (en & hit)};
      time_next  = {1'b0, time_cnt_q} + {{W{1'b0}}, 1'b1};
      count_hit  = (max_count != '0) && (hit_next == {1'b0, max_count});
      time_hit   = (max_time != '0) && (time_next == {1'b0, max_time});
      stop       = en && (abort || count_hit || time_hit);
      cause      = abort     ? CAUSE_ABORT :
                   count_hit ? CAUSE_COUNT :
                   time_hit  ? CAUSE_TIME  : CAUSE_NONE;
      hit_cnt_d  = hit_cnt_q;
      time_cnt_d = time_cnt_q;
      if (clr) begin
         hit_cnt_d  = '0;
         time_cnt_d = '0;
      end else if (en) begin
         if (hit && hit_cnt_q != '1)
            hit_cnt_d = hit_next[W-1:0];
         if (time_cnt_q != '1)
            time_cnt_d = time_next[W-1:0];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hit_cnt_q  <= '0;
         time_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         time_cnt_q <= time_cnt_d;
      end
   end

   assign hit_cnt = hit_cnt_q;
endmodule

// File: rtl/hist_acq_sched.sv
// Frame sequencer for the TDC histogram RAM: arm, acquire, stop, read out, clear, repeat.
module hist_acq_sched
   import hist_acq_pkg::*;
#(
   parameter int INSTR_WIDTH = 32,
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 16,
   parameter int RD_PULSE    = 4,
   parameter int CLR_MARGIN  = 16,
   parameter int RD_TIMEOUT  = 1024
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   cmd_start,
   input  logic                   cmd_abort,
   input  logic [INSTR_WIDTH-1:0] cfg_max_count,
   input  logic [INSTR_WIDTH-1:0] cfg_max_time,
   input  logic [15:0]            cfg_frames,
   input  logic                   hit_in,
   hist_acq_sched_if.master       ram,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   run_done,
   output logic                   rd_err,
   output logic [15:0]            frame_id
);
   localparam int HW         = ADDR_WIDTH + DATA_WIDTH;
   localparam int BEATS      = (1 << ADDR_WIDTH) + 1;
   localparam int CLR_CYCLES = (1 << ADDR_WIDTH) + CLR_MARGIN;

   state_e                 state_q, state_d;
   logic [INSTR_WIDTH-1:0] ph_q, ph_d;
   logic [INSTR_WIDTH-1:0] idle_q, idle_d;
   logic [ADDR_WIDTH:0]    beat_q, beat_d;
   logic [INSTR_WIDTH-1:0] max_count_q, max_count_d, max_time_q, max_time_d;
   logic [15:0]            frames_q, frames_d, frame_id_q, frame_id_d;
   logic [1:0]             cause_q, cause_d;
   logic [HW-1:0]          hdr_q, hdr_d;
   logic                   abort_q, abort_d, rd_err_q, rd_err_d, run_done_q, run_done_d;

   logic                   cnt_clr, lim_stop, beat, last_frame;
   logic [1:0]             lim_cause;
   logic [INSTR_WIDTH-1:0] hit_cnt;
   logic [15:0]            hit_sat;

   hist_limit_cnt #(.W(INSTR_WIDTH)) u_limit (
      .clk       (clk),
      .resetn    (resetn),
      .clr       (cnt_clr),
      .en        (state_q == ACQ),
      .hit       (hit_in),
      .abort     (cmd_abort | abort_q),
      .max_count (max_count_q),
      .max_time  (max_time_q),
      .stop      (lim_stop),
      .cause     (lim_cause),
      .hit_cnt   (hit_cnt)
   );

   always_comb begin
      state_d     = state_q;
      ph_d        = (ph_q == '1) ? ph_q : ph_q + 1'b1;
      idle_d      = idle_q;
      beat_d      = beat_q;
      max_count_d = max_count_q;
      max_time_d  = max_time_q;
      frames_d    = frames_q;
      frame_id_d  = frame_id_q;
      cause_d     = cause_q;
      hdr_d       = hdr_q;
      abort_d     = abort_q;
      rd_err_d    = rd_err_q;
      run_done_d  = 1'b0;
      cnt_clr     = 1'b0;
      beat        = ram.strm_valid & ram.strm_ready;
      hit_sat     = (|hit_cnt[INSTR_WIDTH-1:16]) ? 16'hFFFF : hit_cnt[15:0];
      last_frame  = (frames_q != 16'd0) && ((17'(frame_id_q) + 17'd1) == 17'(frames_q));

      // An abort outside ACQ is remembered so the run still ends at NEXT.
      if (cmd_abort && state_q != IDLE)
         abort_d = 1'b1;

      case (state_q)
         IDLE: if (cmd_start) begin
            state_d     = ARM;
            max_count_d = cfg_max_count;
            max_time_d  = cfg_max_time;
            frames_d    = cfg_frames;
            frame_id_d  = 16'd0;
            rd_err_d    = 1'b0;
            abort_d     = 1'b0;
            cnt_clr     = 1'b1;
         end
         ARM: if (ph_q == INSTR_WIDTH'(ARM_CYCLES - 1))
            state_d = ACQ;
         ACQ: if (lim_stop) begin
            state_d = STOP;
            cause_d = lim_cause;
         end
         STOP: if (ph_q == INSTR_WIDTH'(STOP_CYCLES - 1)) begin
            state_d = READ;
            hdr_d   = HW'(make_hdr(cause_q, frame_id_q[7:0], hit_sat));
            beat_d  = '0;
            idle_d  = '0;
         end
         READ: begin
            if (beat) begin
               idle_d = '0;
               beat_d = beat_q + 1'b1;
               if (beat_q == (ADDR_WIDTH+1)'(BEATS - 1))
                  state_d = CLEAR;
            end else if (idle_q == INSTR_WIDTH'(RD_TIMEOUT - 1)) begin
               rd_err_d = 1'b1;
               state_d  = CLEAR;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
         CLEAR: if (ph_q == INSTR_WIDTH'(CLR_CYCLES - 1))
            state_d = NEXT;
         NEXT: begin
            abort_d = 1'b0;
            if (abort_q || cmd_abort || last_frame) begin
               run_done_d = 1'b1;
               state_d    = IDLE;
            end else begin
               frame_id_d = frame_id_q + 16'd1;
               cnt_clr    = 1'b1;
               state_d    = ARM;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q)
         ph_d = '0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         ph_q        <= '0;
         idle_q      <= '0;
         beat_q      <= '0;
         max_count_q <= '0;
         max_time_q  <= '0;
         frames_q    <= '0;
         frame_id_q  <= '0;
         cause_q     <= CAUSE_NONE;
         hdr_q       <= '0;
         abort_q     <= 1'b0;
         rd_err_q    <= 1'b0;
         run_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ph_q        <= ph_d;
         idle_q      <= idle_d;
         beat_q      <= beat_d;
         max_count_q <= max_count_d;
         max_time_q  <= max_time_d;
         frames_q    <= frames_d;
         frame_id_q  <= frame_id_d;
         cause_q     <= cause_d;
         hdr_q       <= hdr_d;
         abort_q     <= abort_d;
         rd_err_q    <= rd_err_d;
         run_done_q  <= run_done_d;
      end
   end

   assign ram.hit_gate = (state_q == ACQ);
   assign ram.capture  = (state_q == ARM) || (state_q == ACQ) || (state_q == STOP) || (state_q == READ);
   assign ram.rd_en    = (state_q == READ) && (ph_q < INSTR_WIDTH'(RD_PULSE));
   assign ram.header   = hdr_q;
   assign busy         = (state_q != IDLE);
   assign frame_done   = (state_q == NEXT);
   assign run_done     = run_done_q;
   assign rd_err       = rd_err_q;
   assign frame_id     = frame_id_q;
endmodule

// File: tb/tb_hist_acq_sched.sv
// Directed bench for hist_acq_sched: table of frame scenarios plus timeout and reset sequences.
module tb_hist_acq_sched;
   localparam int AW = 4;
   localparam int DW = 28;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        cmd_start = 1'b0, cmd_abort = 1'b0, hit_in = 1'b0;
   logic [31:0] cfg_max_count = '0, cfg_max_time = '0;
   logic [15:0] cfg_frames = '0;
   logic        busy, frame_done, run_done, rd_err;
   logic [15:0] frame_id;

   hist_acq_sched_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram_if ();

   hist_acq_sched #(
      .INSTR_WIDTH(32), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .RD_PULSE(4), .CLR_MARGIN(16), .RD_TIMEOUT(64)
   ) dut (
      .clk(clk), .resetn(resetn), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
      .cfg_max_count(cfg_max_count), .cfg_max_time(cfg_max_time), .cfg_frames(cfg_frames),
      .hit_in(hit_in), .ram(ram_if), .busy(busy), .frame_done(frame_done),
      .run_done(run_done), .rd_err(rd_err), .frame_id(frame_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] max_count;
      logic [31:0] max_time;
      logic [15:0] frames;
      int          hits;
      int          abort_at;
      int          exp_nfr;
      int          exp_acq;
      logic [31:0] exp_hdr;
   } vec_t;

   vec_t vecs[6];
   int   n_checks = 0;
   int   n_fail   = 0;

   int          acq_a[8], rd_a[8], rl_a[8], cl_a[8], fid_a[8];
   logic [31:0] hdr_a[8];
   logic        stab_a[8];
   int          nfr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int   hits_left, acq_total, cyc, k;
      logic prev_rd, in_read;
      for (int i = 0; i < 8; i++) begin
         acq_a[i] = 0; rd_a[i] = 0; rl_a[i] = 0; cl_a[i] = 0; fid_a[i] = -1;
         hdr_a[i] = '0; stab_a[i] = 1'b1;
      end
      nfr = 0; hits_left = v.hits; acq_total = 0; prev_rd = 1'b0; in_read = 1'b0;
      cfg_max_count = v.max_count; cfg_max_time = v.max_time; cfg_frames = v.frames;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      cyc = 0;
      while (!run_done && cyc < 4000) begin
         k = (nfr < 8) ? nfr : 7;
         hit_in = 1'b0;
         cmd_abort = 1'b0;
         if (ram_if.hit_gate) begin
            acq_a[k]++;
            acq_total++;
            if (hits_left > 0) begin
               hit_in = 1'b1;
               hits_left--;
            end
            if (v.abort_at != 0 && acq_total == v.abort_at)
               cmd_abort = 1'b1;
         end
         if (ram_if.rd_en) begin
            rd_a[k]++;
            if (!prev_rd) begin
               hdr_a[k] = ram_if.header;
               in_read  = 1'b1;
            end
         end
         if (in_read) begin
            if (ram_if.capture) begin
               rl_a[k]++;
               if (ram_if.header !== hdr_a[k]) stab_a[k] = 1'b0;
            end else begin
               in_read = 1'b0;
            end
         end
         if (busy && !ram_if.capture && !frame_done) cl_a[k]++;
         if (frame_done) begin
            fid_a[k] = int'(frame_id);
            nfr++;
         end
         prev_rd = ram_if.rd_en;
         @(negedge clk);
         cyc++;
      end
      hit_in = 1'b0;
      cmd_abort = 1'b0;
   endtask

   initial begin
      int          n, fd, rises;
      logic        prev;
      logic [31:0] hk;

      //           max_count max_time frames hits abort nfr acq  header
      vecs[0] = '{32'd5,  32'd0,   16'd1, 7, 0,  1, 5,   32'hA400_0005};
      vecs[1] = '{32'd0,  32'd100, 16'd1, 0, 0,  1, 100, 32'hA800_0000};
      vecs[2] = '{32'd3,  32'd3,   16'd1, 3, 0,  1, 3,   32'hA400_0003};
      vecs[3] = '{32'd0,  32'd20,  16'd3, 0, 0,  3, 20,  32'hA800_0000};
      vecs[4] = '{32'd10, 32'd8,   16'd1, 4, 0,  1, 8,   32'hA800_0004};
      vecs[5] = '{32'd0,  32'd0,   16'd0, 2, 10, 1, 10,  32'hAC00_0002};

      ram_if.strm_valid = 1'b1;
      ram_if.strm_ready = 1'b1;

      repeat (3) @(negedge clk);
      chk("reset_outs", {busy, frame_done, run_done, rd_err, frame_id,
                         ram_if.hit_gate, ram_if.capture, ram_if.rd_en}, '0);
      resetn = 1'b1;
      @(negedge clk);
      chk("post_reset_outs", {busy, frame_done, run_done, rd_err, frame_id,
                              ram_if.hit_gate, ram_if.capture, ram_if.rd_en, ram_if.header}, '0);

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i]);
         chk($sformatf("v%0d_run_done", i), run_done, 1'b1);
         chk($sformatf("v%0d_nframes", i), nfr, vecs[i].exp_nfr);
         for (int k = 0; k < vecs[i].exp_nfr; k++) begin
            hk = vecs[i].exp_hdr | (32'(k) << 16);
            chk($sformatf("v%0d_f%0d_acq", i, k), acq_a[k], vecs[i].exp_acq);
            chk($sformatf("v%0d_f%0d_hdr", i, k), hdr_a[k], hk);
            chk($sformatf("v%0d_f%0d_hdr_stable", i, k), stab_a[k], 1'b1);
            chk($sformatf("v%0d_f%0d_rd_en_len", i, k), rd_a[k], 4);
            chk($sformatf("v%0d_f%0d_read_len", i, k), rl_a[k], 17);
            chk($sformatf("v%0d_f%0d_clear_len", i, k), cl_a[k], 32);
            chk($sformatf("v%0d_f%0d_frame_id", i, k), fid_a[k], k);
         end
         chk($sformatf("v%0d_rd_err", i), rd_err, 1'b0);
         $display("vec %0d: frames=%0d hdr0=%h acq0=%0d", i, nfr, hdr_a[0], acq_a[0]);
         @(negedge clk);
         chk($sformatf("v%0d_run_done_pulse", i), run_done, 1'b0);
         chk($sformatf("v%0d_idle", i), busy, 1'b0);
      end

      // Readout timeout: downstream never ready.
      ram_if.strm_ready = 1'b0;
      cfg_max_count = 0; cfg_max_time = 10; cfg_frames = 1;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      n = 0;
      while (!ram_if.rd_en && n < 200) begin @(negedge clk); n++; end
      chk("to_rd_en", ram_if.rd_en, 1'b1);
      n = 0;
      while (!rd_err && n < 200) begin n++; @(negedge clk); end
      chk("to_idle_cycles", n, 64);
      chk("to_clear_capture", ram_if.capture, 1'b0);
      fd = 0; n = 0;
      while (!run_done && n < 200) begin
         if (frame_done) fd++;
         @(negedge clk);
         n++;
      end
      chk("to_frame_done", fd, 1);
      chk("to_run_done", run_done, 1'b1);
      chk("to_rd_err_sticky", rd_err, 1'b1);
      $display("timeout: idle_cycles=64 rd_err=%0b", rd_err);
      ram_if.strm_ready = 1'b1;
      cfg_max_time = 3;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      chk("to_rd_err_cleared", rd_err, 1'b0);
      chk("to_restart_busy", busy, 1'b1);
      n = 0;
      while (!run_done && n < 400) begin @(negedge clk); n++; end
      chk("to_restart_done", run_done, 1'b1);
      @(negedge clk);

      // Async reset in the middle of the second frame's readout.
      cfg_max_time = 5; cfg_frames = 2;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      rises = 0; prev = 1'b0; n = 0;
      while (rises < 2 && n < 500) begin
         @(negedge clk);
         n++;
         if (ram_if.rd_en && !prev) rises++;
         prev = ram_if.rd_en;
      end
      chk("rst_second_read", rises, 2);
      @(negedge clk);
      chk("rst_hdr_frame1", ram_if.header, 32'hA801_0000);
      chk("rst_frame_id1", frame_id, 16'd1);
      #2 resetn = 1'b0;
      #1;
      chk("rst_async_outs", {busy, frame_done, run_done, rd_err, frame_id,
                             ram_if.hit_gate, ram_if.capture, ram_if.rd_en}, '0);
      chk("rst_async_hdr", ram_if.header, '0);
      $display("reset: busy=%0b capture=%0b rd_en=%0b", busy, ram_if.capture, ram_if.rd_en);
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_stays_idle", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
